// File: rtl/prefix_eval_sched_if.sv
// Handshake bundle between requesters, the scheduler and the shared evaluator.
// slave: scheduler side. master: requesters plus evaluator side.
interface prefix_eval_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int TOK_NUM = 19
);
    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EXPW = TOK_NUM * 5;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_opt;
    logic [NUM_REQ-1:0][EXPW-1:0] req_expr;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         busy;
    logic                         eval_in_valid;
    logic                         eval_opt;
    logic [4:0]                   eval_in_data;
    logic                         eval_out_valid;
    logic [EXPW-1:0]              eval_out;
    logic                         resp_valid;
    logic [IDW-1:0]               resp_id;
    logic                         resp_opt;
    logic [EXPW-1:0]              resp_data;
    logic                         resp_err;

    modport slave (
        input  req_valid, req_opt, req_expr,
        input  eval_out_valid, eval_out,
        output req_ready, busy,
        output eval_in_valid, eval_opt, eval_in_data,
        output resp_valid, resp_id, resp_opt,
        output resp_data, resp_err
    );

    modport master (
        output req_valid, req_opt, req_expr,
        output eval_out_valid, eval_out,
        input  req_ready, busy,
        input  eval_in_valid, eval_opt, eval_in_data,
        input  resp_valid, resp_id, resp_opt,
        input  resp_data, resp_err
    );
endinterface

// File: rtl/prefix_eval_sched.sv
// Round-robin scheduler feeding one shared prefix/infix evaluator.
// Ports: clk, rst_n (async, active-low), bus (prefix_eval_sched_if.slave):
//   req_valid/req_opt/req_expr in, req_ready out (one-hot grant pulse),
//   eval_in_valid/eval_opt/eval_in_data out, eval_out_valid/eval_out in,
//   resp_valid/resp_id/resp_opt/resp_data/resp_err out, busy out.
// Optional macro PSCHED_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYC).
module prefix_eval_sched #(
    parameter int NUM_REQ = 4,
    parameter int TOK_NUM = 19
`ifdef PSCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input logic                clk,
    input logic                rst_n,
    prefix_eval_sched_if.slave bus
);
    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EXPW = TOK_NUM * 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                     r_state;
    logic [IDW-1:0]             r_rr;
    logic [IDW-1:0]             r_id;
    logic                       r_opt;
    logic [TOK_NUM-1:0][4:0]    r_expr;
    logic [4:0]                 r_cnt;
    logic [NUM_REQ-1:0]         r_req_ready;
    logic                       r_busy;
    logic                       r_in_valid;
    logic                       r_eval_opt;
    logic [4:0]                 r_in_data;
    logic                       r_resp_valid;
    logic [IDW-1:0]             r_resp_id;
    logic                       r_resp_opt;
    logic [EXPW-1:0]            r_resp_data;
    logic                       r_resp_err;
`ifdef PSCHED_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    logic [WCW-1:0]             r_wcnt;
`endif

    logic                       w_found;
    logic [IDW-1:0]             w_gnt;
    logic [IDW:0]               w_sum;
    logic [IDW-1:0]             w_idx;
    logic [IDW-1:0]             w_next_rr;

    // Search from r_rr upward, wrapping at NUM_REQ (need not be a power of 2).
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(NUM_REQ))
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            w_idx = w_sum[IDW-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_next_rr = (w_gnt == IDW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_id         <= '0;
            r_opt        <= 1'b0;
            r_expr       <= '0;
            r_cnt        <= '0;
            r_req_ready  <= '0;
            r_busy       <= 1'b0;
            r_in_valid   <= 1'b0;
            r_eval_opt   <= 1'b0;
            r_in_data    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_opt   <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
`ifdef PSCHED_TIMEOUT_EN
            r_wcnt       <= '0;
`endif
        end else begin
            r_req_ready  <= '0;
            r_resp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt;
                        r_id        <= w_gnt;
                        r_opt       <= bus.req_opt[w_gnt];
                        r_expr      <= bus.req_expr[w_gnt];
                        r_rr        <= w_next_rr;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Opt travels only with the first token.
                    r_in_valid <= 1'b1;
                    r_in_data  <= r_expr[r_cnt];
                    r_eval_opt <= (r_cnt == '0) ? r_opt : 1'b0;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == 5'(TOK_NUM - 1))
                        r_state <= S_WAIT;
`ifdef PSCHED_TIMEOUT_EN
                    r_wcnt     <= '0;
`endif
                end
                S_WAIT: begin
                    r_in_valid <= 1'b0;
                    r_in_data  <= '0;
                    r_eval_opt <= 1'b0;
                    if (bus.eval_out_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_id;
                        r_resp_opt   <= r_opt;
                        r_resp_data  <= bus.eval_out;
                        r_resp_err   <= 1'b0;
                        r_state      <= S_RESP;
                    end
`ifdef PSCHED_TIMEOUT_EN
                    else if (r_wcnt == WCW'(TIMEOUT_CYC - 1)) begin
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_id;
                        r_resp_opt   <= r_opt;
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.busy          = r_busy;
    assign bus.eval_in_valid = r_in_valid;
    assign bus.eval_opt      = r_eval_opt;
    assign bus.eval_in_data  = r_in_data;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_id       = r_resp_id;
    assign bus.resp_opt      = r_resp_opt;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_err      = r_resp_err;
endmodule
